jtag_management_controller: RTL



---
 rtl/jtag_management_controller.sv | 113 +++++++++++
 1 files changed

// File: rtl/jtag_management_controller.sv
// Management-bus sequencer for the JTAG TAP: issues one registered request per DR update,
// rides out target stalls up to a timeout, and reports read data plus sticky status.
module jtag_management_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        command_valid,
  input  logic        command_write,
  input  logic [3:0]  command_byteSelect,
  input  logic [19:0] command_address,
  input  logic [31:0] command_writeData,
  input  logic        status_clear,
  output logic        status_busy,
  output logic        status_done,
  output logic        status_error,
  output logic        status_overrun,
  output logic [31:0] status_readData,
  output logic        management_writeEnable,
  output logic        management_readEnable,
  output logic [3:0]  management_byteSelect,
  output logic [19:0] management_address,
  output logic [31:0] management_writeData,
  input  logic [31:0] management_readData,
  input  logic        management_busy
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, REQUEST, CAPTURE} state_t;

  state_t           state;
  logic             isWrite;
  logic [CNT_W-1:0] timer;

  // Sticky bits: clears are written first so any same-cycle set event overrides them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= IDLE;
      isWrite                <= 1'b0;
      timer                  <= '0;
      status_busy            <= 1'b0;
      status_done            <= 1'b0;
      status_error           <= 1'b0;
      status_overrun         <= 1'b0;
      status_readData        <= '0;
      management_writeEnable <= 1'b0;
      management_readEnable  <= 1'b0;
      management_byteSelect  <= 4'b1111;
      management_address     <= '0;
      management_writeData   <= '0;
    end else begin
      if (status_clear) begin
        status_done    <= 1'b0;
        status_error   <= 1'b0;
        status_overrun <= 1'b0;
      end
      if (command_valid && (state != IDLE)) status_overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (command_valid) begin
            isWrite                <= command_write;
            management_writeEnable <= command_write;
            management_readEnable  <= ~command_write;
            management_byteSelect  <= command_byteSelect;
            management_address     <= command_address;
            management_writeData   <= command_writeData;
            timer                  <= CNT_W'(TIMEOUT_CYCLES - 1);
            status_done            <= 1'b0;
            status_error           <= 1'b0;
            status_busy            <= 1'b1;
            state                  <= REQUEST;
          end
        end
        REQUEST: begin
          if (!management_busy) begin
            management_writeEnable <= 1'b0;
            management_readEnable  <= 1'b0;
            if (isWrite) begin
              status_done <= 1'b1;
              status_busy <= 1'b0;
              state       <= IDLE;
            end else begin
              state <= CAPTURE;
            end
          end else if (timer == '0) begin
            management_writeEnable <= 1'b0;
            management_readEnable  <= 1'b0;
            status_error           <= 1'b1;
            status_busy            <= 1'b0;
            state                  <= IDLE;
          end else begin
            timer <= timer - CNT_W'(1);
          end
        end
        CAPTURE: begin
          status_readData <= management_readData;
          status_done     <= 1'b1;
          status_busy     <= 1'b0;
          state           <= IDLE;
        end
        default: begin
          management_writeEnable <= 1'b0;
          management_readEnable  <= 1'b0;
          status_busy            <= 1'b0;
          state                  <= IDLE;
        end
      endcase
    end
  end

endmodule
